sobel_stream_v2: RTL and testbench

- Parametrised successor to the single-threshold Sobel edge stage in the grayscale pipeline (median filter -> Sobel).
- Builds the 3x3 window internally from a raster pixel stream using two line buffers.
- Computes |Gx|+|Gy|, then outputs two results per pixel:
  - a saturated gradient magnitude;
  - a 1-bit edge flag against a threshold that can be loaded at runtime.
- Tolerates valid gaps and keeps hsync/vsync aligned with the data.

---
 rtl/sobel_stream_v2.sv | 181 ++++++++++++++++++
 tb/tb_sobel_stream_v2.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_v2.sv
// Streaming 3x3 Sobel edge stage: two line buffers, 4-stage pipeline, runtime threshold.
// Define SOBEL_FRAME_STATS_EN to add per-frame edge count outputs (frame_edge_count, frame_done).
module sobel_stream_v2 #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 200,
  parameter int HEIGHT     = 200,
  parameter int THRESHOLD  = 128
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_in_valid,
  input  logic                  pix_in_hsync,
  input  logic                  pix_in_vsync,
  input  logic [DATA_WIDTH+2:0] thresh_in,
  input  logic                  thresh_load,
  output logic [DATA_WIDTH-1:0] sobel_mag,
  output logic                  sobel_edge,
  output logic                  sobel_valid,
  output logic                  sobel_hsync,
`ifdef SOBEL_FRAME_STATS_EN
  output logic                  sobel_vsync,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0] frame_edge_count,
  output logic                  frame_done
`else
  output logic                  sobel_vsync
`endif
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int SW    = DATA_WIDTH + 4;
  localparam int AW    = DATA_WIDTH + 2;
  localparam int TW    = DATA_WIDTH + 3;
  localparam logic [TW-1:0] MAG_MAX = TW'((1 << DATA_WIDTH) - 1);

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [TW-1:0]         thresh_q;
  logic [DATA_WIDTH-1:0] lb1_mem [WIDTH];
  logic [DATA_WIDTH-1:0] lb2_mem [WIDTH];
  logic [DATA_WIDTH-1:0] lb1_rd, lb2_rd;
  logic [DATA_WIDTH-1:0] w_q [3][3];
  logic                  border_d, border1_q, border2_q, border3_q;
  logic signed [SW-1:0]  gx_d, gy_d, gx2_q, gy2_q;
  logic [AW-1:0]         ax_d, ay_d, ax3_q, ay3_q;
  logic [TW-1:0]         sum4;
  logic [DATA_WIDTH-1:0] mag_d, mag_q;
  logic                  edge_d, edge_q;
  logic [3:0]            vld_q, hs_q, vs_q;

  function automatic logic signed [SW-1:0] px(input logic [DATA_WIDTH-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (!pix_in_vsync) begin
      col_d = '0;
      row_d = '0;
    end else if (pix_in_valid) begin
      if (col_q == COL_W'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // The window is incomplete until two full rows and two columns have arrived.
  assign border_d = !pix_in_vsync || (32'(row_q) < 32'd2) || (32'(col_q) < 32'd2);

  assign lb1_rd = lb1_mem[col_q];
  assign lb2_rd = lb2_mem[col_q];

  always_ff @(posedge clk) begin
    if (pix_in_valid) begin
      lb1_mem[col_q] <= pix_in;
      lb2_mem[col_q] <= lb1_rd;
    end
  end

  always_comb begin
    gx_d = (px(w_q[0][2]) + (px(w_q[1][2]) <<< 1) + px(w_q[2][2]))
         - (px(w_q[0][0]) + (px(w_q[1][0]) <<< 1) + px(w_q[2][0]));
    gy_d = (px(w_q[2][0]) + (px(w_q[2][1]) <<< 1) + px(w_q[2][2]))
         - (px(w_q[0][0]) + (px(w_q[0][1]) <<< 1) + px(w_q[0][2]));
    ax_d = AW'(gx2_q[SW-1] ? -gx2_q : gx2_q);
    ay_d = AW'(gy2_q[SW-1] ? -gy2_q : gy2_q);
    sum4 = TW'(ax3_q) + TW'(ay3_q);
    mag_d  = '0;
    edge_d = 1'b0;
    if (!border3_q) begin
      mag_d  = (sum4 > MAG_MAX) ? '1 : sum4[DATA_WIDTH-1:0];
      edge_d = (sum4 >= thresh_q);
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      col_q     <= '0;
      row_q     <= '0;
      thresh_q  <= TW'(THRESHOLD);
      border1_q <= 1'b1;
      border2_q <= 1'b1;
      border3_q <= 1'b1;
      gx2_q     <= '0;
      gy2_q     <= '0;
      ax3_q     <= '0;
      ay3_q     <= '0;
      mag_q     <= '0;
      edge_q    <= 1'b0;
      vld_q     <= '0;
      hs_q      <= '0;
      vs_q      <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w_q[i][j] <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (thresh_load) thresh_q <= thresh_in;
      // Window and border flag only move on accepted pixels; later stages run freely.
      if (pix_in_valid) begin
        for (int i = 0; i < 3; i++) begin
          w_q[i][0] <= w_q[i][1];
          w_q[i][1] <= w_q[i][2];
        end
        w_q[0][2] <= lb2_rd;
        w_q[1][2] <= lb1_rd;
        w_q[2][2] <= pix_in;
        border1_q <= border_d;
      end
      gx2_q     <= gx_d;
      gy2_q     <= gy_d;
      border2_q <= border1_q;
      ax3_q     <= ax_d;
      ay3_q     <= ay_d;
      border3_q <= border2_q;
      mag_q     <= mag_d;
      edge_q    <= edge_d;
      vld_q     <= {vld_q[2:0], pix_in_valid};
      hs_q      <= {hs_q[2:0], pix_in_hsync};
      vs_q      <= {vs_q[2:0], pix_in_vsync};
    end
  end

  assign sobel_mag   = mag_q;
  assign sobel_edge  = edge_q;
  assign sobel_valid = vld_q[3];
  assign sobel_hsync = hs_q[3];
  assign sobel_vsync = vs_q[3];

`ifdef SOBEL_FRAME_STATS_EN
  localparam int CW = $clog2(WIDTH*HEIGHT+1);
  logic [CW-1:0] edge_cnt_q;
  logic          vs_prev_q;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      edge_cnt_q       <= '0;
      vs_prev_q        <= 1'b0;
      frame_edge_count <= '0;
      frame_done       <= 1'b0;
    end else begin
      vs_prev_q  <= sobel_vsync;
      frame_done <= 1'b0;
      if (vs_prev_q && !sobel_vsync) begin
        frame_edge_count <= edge_cnt_q;
        frame_done       <= 1'b1;
        edge_cnt_q       <= '0;
      end else if (sobel_vsync && sobel_valid && sobel_edge) begin
        edge_cnt_q <= edge_cnt_q + CW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sobel_stream_v2.sv
// Scoreboard bench for sobel_stream_v2 on an 8x8 frame; table of frame scenarios plus reset sequences.
// Build with SOBEL_FRAME_STATS_EN defined to also check the frame statistics outputs.
module tb_sobel_stream_v2;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int HIST = 10000;

  logic          clk = 1'b0;
  logic          reset_p;
  logic [DW-1:0] pix_in;
  logic          pix_in_valid, pix_in_hsync, pix_in_vsync;
  logic [DW+2:0] thresh_in;
  logic          thresh_load;
  logic [DW-1:0] sobel_mag;
  logic          sobel_edge, sobel_valid, sobel_hsync, sobel_vsync;
`ifdef SOBEL_FRAME_STATS_EN
  logic [$clog2(W*H+1)-1:0] frame_edge_count;
  logic                     frame_done;
`endif

  sobel_stream_v2 #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H), .THRESHOLD(128)) dut (
    .clk(clk), .reset_p(reset_p),
    .pix_in(pix_in), .pix_in_valid(pix_in_valid),
    .pix_in_hsync(pix_in_hsync), .pix_in_vsync(pix_in_vsync),
    .thresh_in(thresh_in), .thresh_load(thresh_load),
    .sobel_mag(sobel_mag), .sobel_edge(sobel_edge), .sobel_valid(sobel_valid),
    .sobel_hsync(sobel_hsync),
`ifdef SOBEL_FRAME_STATS_EN
    .sobel_vsync(sobel_vsync),
    .frame_edge_count(frame_edge_count), .frame_done(frame_done)
`else
    .sobel_vsync(sobel_vsync)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int mag; int edg; int cyc; } exp_t;
  typedef struct { int pattern; int gap; int thr; int load_row; int load_val; int exp_edges; } vec_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   vhist [HIST];
  int   img [H][W];
  int   thr_model = 128;
  int   n_checks = 0;
  int   n_fail = 0;
  int   dut_edges = 0;
  int   done_cnt = 0;
  int   last_fec = 0;
  int   exp_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (cyc < HIST) vhist[cyc] = reset_p ? 0 : int'(pix_in_valid);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset_p && cyc >= 4 && cyc < HIST + 4) check("valid_pattern", int'(sobel_valid), vhist[cyc-4]);
    if (sobel_valid) begin
      if (sbq.size() == 0) check("unexpected_output", 1, 0);
      else begin
        e = sbq.pop_front();
        check("mag", int'(sobel_mag), e.mag);
        check("edge", int'(sobel_edge), e.edg);
        check("hsync", int'(sobel_hsync), 1);
        check("vsync", int'(sobel_vsync), 1);
        check("latency", cyc - e.cyc, 4);
      end
      if (sobel_edge) dut_edges++;
    end
`ifdef SOBEL_FRAME_STATS_EN
    if (frame_done) begin
      done_cnt++;
      last_fec = int'(frame_edge_count);
    end
`endif
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic push_model(input int r, input int c);
    exp_t e;
    int gx, gy, sum;
    e.mag = 0;
    e.edg = 0;
    e.cyc = cyc;
    if (r >= 2 && c >= 2) begin
      gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
      gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
      sum = iabs(gx) + iabs(gy);
      e.mag = (sum > 255) ? 255 : sum;
      e.edg = (sum >= thr_model) ? 1 : 0;
    end
    sbq.push_back(e);
  endtask

  task automatic drive(input int p, input int v, input int hs, input int vs);
    @(negedge clk);
    pix_in       = DW'(p);
    pix_in_valid = v[0];
    pix_in_hsync = hs[0];
    pix_in_vsync = vs[0];
  endtask

  task automatic load_thresh(input int v);
    @(negedge clk);
    pix_in_valid = 1'b0;
    thresh_in    = 11'(v);
    thresh_load  = 1'b1;
    @(negedge clk);
    thresh_load  = 1'b0;
    thr_model    = v;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mag"}, int'(sobel_mag), 0);
    check({tag, "_edge"}, int'(sobel_edge), 0);
    check({tag, "_valid"}, int'(sobel_valid), 0);
    check({tag, "_hsync"}, int'(sobel_hsync), 0);
    check({tag, "_vsync"}, int'(sobel_vsync), 0);
`ifdef SOBEL_FRAME_STATS_EN
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_frame_edge_count"}, int'(frame_edge_count), 0);
`endif
  endtask

  // Mid-frame reset, with a coincident threshold load that must lose to reset.
  task automatic do_reset();
    @(negedge clk);
    reset_p      = 1'b1;
    pix_in_valid = 1'b0;
    pix_in_hsync = 1'b0;
    pix_in_vsync = 1'b0;
    thresh_in    = 11'd50;
    thresh_load  = 1'b1;
    #2;
    sbq.delete();
    for (int k = 1; k <= 3; k++) if (cyc - k >= 0) vhist[cyc-k] = 0;
    check_outputs_zero("reset_mid");
    @(negedge clk);
    thresh_load = 1'b0;
    @(negedge clk);
    reset_p   = 1'b0;
    thr_model = 128;
  endtask

  task automatic run_frame(input int pattern, input int gap, input int load_row,
                           input int load_val, input int abort_row);
    int gcnt = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (pattern == 0) ? 100 : (pattern == 1) ? ((c < 4) ? 0 : 255) : 10 * c;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == load_row && c == 0) begin
          repeat (6) drive(0, 0, 0, 1);
          load_thresh(load_val);
          repeat (2) drive(0, 0, 0, 1);
        end
        if (r == abort_row && c == 3) begin
          do_reset();
          return;
        end
        if (gap != 0 && (gcnt % 3) == 2) begin
          drive(img[r][c], 0, 1, 1);
          gcnt++;
        end
        drive(img[r][c], 1, 1, 1);
        push_model(r, c);
        gcnt++;
        if (c == W - 1) begin
          drive(0, 0, 0, 1);
          gcnt++;
        end
      end
    end
    repeat (10) drive(0, 0, 0, 0);
  endtask

  task automatic frame_checks(input string tag, input int exp_edges);
    check({tag, "_edge_total"}, dut_edges, exp_edges);
    check({tag, "_queue_drained"}, sbq.size(), 0);
`ifdef SOBEL_FRAME_STATS_EN
    check({tag, "_frame_done_pulses"}, done_cnt, exp_done);
    check({tag, "_frame_edge_count"}, last_fec, exp_edges);
`endif
  endtask

  vec_t tbl[5];

  initial begin
    // pattern: 0 flat 100, 1 vertical step at col 4, 2 ramp 10*col
    tbl[0] = '{pattern: 0, gap: 0, thr: 128, load_row: -1, load_val: 0,  exp_edges: 0};
    tbl[1] = '{pattern: 1, gap: 0, thr: 128, load_row: -1, load_val: 0,  exp_edges: 12};
    tbl[2] = '{pattern: 2, gap: 0, thr: 128, load_row: -1, load_val: 0,  exp_edges: 0};
    tbl[3] = '{pattern: 2, gap: 0, thr: 128, load_row: 4,  load_val: 64, exp_edges: 24};
    tbl[4] = '{pattern: 1, gap: 1, thr: 128, load_row: -1, load_val: 0,  exp_edges: 12};

    for (int i = 0; i < HIST; i++) vhist[i] = 0;
    reset_p = 1'b1;
    pix_in = '0; pix_in_valid = 1'b0; pix_in_hsync = 1'b0; pix_in_vsync = 1'b0;
    thresh_in = '0; thresh_load = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_init");
    reset_p = 1'b0;
    repeat (3) drive(0, 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].thr != thr_model) load_thresh(tbl[i].thr);
      repeat (2) drive(0, 0, 0, 0);
      dut_edges = 0;
      run_frame(tbl[i].pattern, tbl[i].gap, tbl[i].load_row, tbl[i].load_val, -1);
      exp_done++;
      frame_checks($sformatf("frame%0d", i), tbl[i].exp_edges);
    end

    // Abort a step frame in row 4, then restart with vsync low -> high.
    run_frame(1, 0, -1, 0, 4);
    repeat (5) drive(0, 0, 0, 0);
    check("abort_no_output_queue", sbq.size(), 0);
    dut_edges = 0;
    run_frame(1, 0, -1, 0, -1);
    exp_done++;
    frame_checks("restart_step", 12);

    // Threshold must still be 128 (load during reset ignored): ramp sum 80 gives no edges.
    dut_edges = 0;
    run_frame(2, 0, -1, 0, -1);
    exp_done++;
    frame_checks("post_reset_ramp", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
